// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: one Wishbone classic port; master modport drives the request, slave modport answers it
interface wb_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          cyc;
  logic          stb;
  logic          we;
  logic [DW/8-1:0] sel;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_w;
  logic          ack;
  logic          err;
  logic [DW-1:0] dat_r;
  modport master (output cyc, stb, we, sel, adr, dat_w, input ack, err, dat_r);
  modport slave  (input cyc, stb, we, sel, adr, dat_w, output ack, err, dat_r);
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin two-master Wishbone arbiter; WB_ARB_TIMEOUT_EN adds an ack-wait timeout
module wb_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  wb_arbiter_if.slave   wbi,
  wb_arbiter_if.slave   wbd,
  wb_arbiter_if.master  wbs
);
  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;
  state_t state_q, state_d;
  logic   last_d_q, last_d_d;
  logic   gi, gd, to;
  assign gi = state_q == GNT_I;
  assign gd = state_q == GNT_D;
`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign to = cnt_q == CW'(TIMEOUT);
  // count consecutive unanswered strobe cycles within one grant
  always_comb
    cnt_d = (state_d != state_q || to || wbs.ack || wbs.err || !wbs.stb) ? '0 : cnt_q + 1'b1;
  // timeout counter register
  always_ff @(posedge clk)
    cnt_q <= rst ? '0 : cnt_d;
`else
  assign to = 1'b0;
`endif
  // route the granted master to the slave, and terminations back only to it
  always_comb begin
    wbs.cyc   = gi ? wbi.cyc   : gd ? wbd.cyc   : 1'b0;
    wbs.stb   = (gi ? wbi.stb  : gd ? wbd.stb   : 1'b0) & ~to;
    wbs.we    = gi ? wbi.we    : gd ? wbd.we    : 1'b0;
    wbs.sel   = gi ? wbi.sel   : gd ? wbd.sel   : '0;
    wbs.adr   = gi ? wbi.adr   : gd ? wbd.adr   : '0;
    wbs.dat_w = gi ? wbi.dat_w : gd ? wbd.dat_w : '0;
    wbi.ack   = gi & wbs.ack & ~to;
    wbd.ack   = gd & wbs.ack & ~to;
    wbi.err   = gi & (wbs.err | to);
    wbd.err   = gd & (wbs.err | to);
    wbi.dat_r = wbs.dat_r;
    wbd.dat_r = wbs.dat_r;
  end
  // arbitration: tie goes to the master not granted last; grant held until cyc drops
  always_comb begin
    state_d  = state_q == IDLE
             ? (wbi.cyc && (!wbd.cyc || last_d_q) ? GNT_I : wbd.cyc ? GNT_D : IDLE)
             : ((gi && !wbi.cyc) || (gd && !wbd.cyc)) ? IDLE : state_q;
    last_d_d = (gi && !wbi.cyc) ? 1'b0 : (gd && !wbd.cyc) ? 1'b1 : last_d_q;
  end
  // state and last-grant registers
  always_ff @(posedge clk)
    if (rst) begin
      state_q  <= IDLE;
      last_d_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: scoreboard bench for wb_arbiter
module tb_wb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  wb_arbiter_if #(.AW(32), .DW(32)) wbi_if ();
  wb_arbiter_if #(.AW(32), .DW(32)) wbd_if ();
  wb_arbiter_if #(.AW(32), .DW(32)) wbs_if ();
  wb_arbiter #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .wbi (wbi_if),
    .wbd (wbd_if),
    .wbs (wbs_if)
  );
  typedef struct {
    bit          d;
    logic [31:0] adr;
    logic [31:0] dat;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input bit d, input bit c, input bit we, input logic [31:0] a);
    if (d) begin
      wbd_if.cyc = c; wbd_if.stb = c; wbd_if.we = we; wbd_if.adr = a; wbd_if.dat_w = ~a;
    end else begin
      wbi_if.cyc = c; wbi_if.stb = c; wbi_if.we = we; wbi_if.adr = a; wbi_if.dat_w = ~a;
    end
  endtask
  task automatic push(input bit d, input logic [31:0] a, input logic [31:0] v);
    exp_t e;
    e.d = d; e.adr = a; e.dat = v;
    sb.push_back(e);
  endtask
  // wait for a granted strobe, ack it and compare against the oldest expectation
  task automatic beat();
    exp_t e;
    int n;
    #1;
    n = 0;
    while (!(wbs_if.cyc && wbs_if.stb) && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) begin
      chk("grant_wait", 0, 1);
      return;
    end
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
      return;
    end
    e = sb.pop_front();
    chk("bus_adr", wbs_if.adr, e.adr);
    wbs_if.ack = 1'b1;
    wbs_if.dat_r = e.dat;
    #1;
    chk("ack_owner", e.d ? wbd_if.ack : wbi_if.ack, 1);
    chk("ack_other", e.d ? wbi_if.ack : wbd_if.ack, 0);
    chk("dat_r", e.d ? wbd_if.dat_r : wbi_if.dat_r, e.dat);
    tick();
    wbs_if.ack = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    bit exp_err;
    drv(0, 0, 0, 0);
    drv(1, 0, 0, 0);
    wbi_if.sel = 4'hF; wbd_if.sel = 4'hF;
    wbs_if.ack = 0; wbs_if.err = 0; wbs_if.dat_r = 0;
    do_reset();
    chk("rst_cyc", wbs_if.cyc, 0);
    chk("rst_stb", wbs_if.stb, 0);
    chk("rst_iack", wbi_if.ack, 0);
    chk("rst_dack", wbd_if.ack, 0);
    // single I read, ack on second granted cycle
    drv(0, 1, 0, 32'h100);
    push(0, 32'h100, 32'hDEADBEEF);
    #1;
    chk("req_latency_cyc", wbs_if.cyc, 0);
    tick();
    chk("rd_adr", wbs_if.adr, 32'h100);
    chk("rd_wait_iack", wbi_if.ack, 0);
    chk("rd_wait_dack", wbd_if.ack, 0);
    tick();
    beat();
    drv(0, 0, 0, 0);
    tick();
    chk("rd_idle_cyc", wbs_if.cyc, 0);
    // ties after reset: I, then D, then I, then D
    do_reset();
    drv(0, 1, 0, 32'h10);
    drv(1, 1, 0, 32'h20);
    push(0, 32'h10, 32'h1111);
    push(1, 32'h20, 32'h2222);
    beat();
    drv(0, 0, 0, 0);
    tick();
    chk("tie_idle_gap", wbs_if.cyc, 0);
    beat();
    drv(1, 0, 0, 0);
    tick();
    drv(0, 1, 0, 32'h30);
    drv(1, 1, 0, 32'h40);
    push(0, 32'h30, 32'h3333);
    beat();
    drv(0, 0, 0, 0);
    drv(1, 0, 0, 0);
    tick();
    drv(0, 1, 0, 32'h50);
    drv(1, 1, 0, 32'h60);
    push(1, 32'h60, 32'h6666);
    push(0, 32'h50, 32'h5555);
    beat();
    drv(1, 0, 0, 0);
    beat();
    drv(0, 0, 0, 0);
    tick();
    // D burst holds the grant while I waits
    drv(1, 1, 1, 32'h200);
    tick();
    drv(0, 1, 0, 32'h80);
    for (int k = 0; k < 4; k++) push(1, 32'h200 + 32'(4 * k), 32'(k));
    for (int k = 0; k < 4; k++) begin
      wbd_if.adr = 32'h200 + 32'(4 * k);
      beat();
    end
    push(0, 32'h80, 32'h8080);
    drv(1, 0, 0, 0);
    beat();
    drv(0, 0, 0, 0);
    tick();
    // reset in the middle of a D transfer, then a stale ack
    drv(1, 1, 0, 32'h400);
    tick();
    tick();
    chk("mid_gnt_cyc", wbs_if.cyc, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_cyc", wbs_if.cyc, 0);
    wbs_if.ack = 1'b1;
    #1;
    chk("stale_dack", wbd_if.ack, 0);
    chk("stale_iack", wbi_if.ack, 0);
    wbs_if.ack = 1'b0;
    drv(1, 0, 0, 0);
    tick();
    tick();
    // unanswered I read
    drv(0, 1, 0, 32'h300);
    tick();
    for (int k = 0; k < 20; k++) begin
`ifdef WB_ARB_TIMEOUT_EN
      exp_err = k == 16;
`else
      exp_err = 1'b0;
`endif
      chk("to_ierr", wbi_if.err, exp_err);
      chk("to_stb", wbs_if.stb, !exp_err);
      chk("to_derr", wbd_if.err, 0);
      tick();
    end
    drv(0, 0, 0, 0);
    tick();
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
